// File: rtl/mapping_group_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mapping_group_ctrl
// Description : Sequencer for one mapping-group output path. It accepts
//               partial-sum beats over a valid/ready handshake. It walks the
//               four bit-plane shift steps of every group and issues the
//               shift-buffer write/read, accumulate and drain strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module mapping_group_ctrl #(
   parameter int GRP_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             mode_i,
   input  logic [GRP_W-1:0] num_groups_i,
   input  logic             adc_valid_i,
   output logic             adc_ready_o,
   output logic             buf_write_en_1_o,
   output logic             buf_write_en_2_o,
   output logic             buf_read_en_o,
   output logic             mode_o,
   output logic [1:0]       shift_count_o,
   output logic             accum_buf_write_o,
   output logic             accum_buf_read_o,
   output logic [GRP_W-1:0] group_idx_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT1 = 3'd1,
      S_WAIT2 = 3'd2,
      S_READ  = 3'd3,
      S_ACCUM = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       step_q, step_d;
   logic [GRP_W-1:0] grp_q, grp_d;
   logic [GRP_W-1:0] ngrp_q, ngrp_d;
   logic             mode_q, mode_d;
   logic [GRP_W-1:0] last_grp;

   // Index of the final group of the latched run.
   assign last_grp      = ngrp_q - {{(GRP_W-1){1'b0}}, 1'b1};

   assign mode_o        = mode_q;
   assign shift_count_o = step_q;
   assign group_idx_o   = grp_q;

   // State and run-context registers; reset returns to an idle, cleared run.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         step_q  <= 2'd0;
         grp_q   <= '0;
         ngrp_q  <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         grp_q   <= grp_d;
         ngrp_q  <= ngrp_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state sequencing and strobe decode; abort overrides everything.
   always_comb begin
      state_d           = state_q;
      step_d            = step_q;
      grp_d             = grp_q;
      ngrp_d            = ngrp_q;
      mode_d            = mode_q;
      adc_ready_o       = 1'b0;
      buf_write_en_1_o  = 1'b0;
      buf_write_en_2_o  = 1'b0;
      buf_read_en_o     = 1'b0;
      accum_buf_write_o = 1'b0;
      accum_buf_read_o  = 1'b0;
      done_o            = 1'b0;
      busy_o            = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (num_groups_i != '0) begin
                  mode_d  = mode_i;
                  ngrp_d  = num_groups_i;
                  step_d  = 2'd0;
                  grp_d   = '0;
                  state_d = S_WAIT1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT1: begin
            adc_ready_o      = 1'b1;
            buf_write_en_1_o = adc_valid_i;
            if (adc_valid_i) begin
               state_d = mode_q ? S_WAIT2 : S_READ;
            end
         end
         S_WAIT2: begin
            adc_ready_o      = 1'b1;
            buf_write_en_2_o = adc_valid_i;
            if (adc_valid_i) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            buf_read_en_o = 1'b1;
            state_d       = S_ACCUM;
         end
         S_ACCUM: begin
            accum_buf_write_o = 1'b1;
            if (step_q == 2'd3) begin
               state_d = S_DRAIN;
            end else begin
               step_d  = step_q + 2'd1;
               state_d = S_WAIT1;
            end
         end
         S_DRAIN: begin
            accum_buf_read_o = 1'b1;
            step_d           = 2'd0;
            if (grp_q == last_grp) begin
               state_d = S_DONE;
            end else begin
               grp_d   = grp_q + {{(GRP_W-1){1'b0}}, 1'b1};
               state_d = S_WAIT1;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_i) begin
         adc_ready_o       = 1'b0;
         buf_write_en_1_o  = 1'b0;
         buf_write_en_2_o  = 1'b0;
         buf_read_en_o     = 1'b0;
         accum_buf_write_o = 1'b0;
         accum_buf_read_o  = 1'b0;
         done_o            = 1'b0;
         state_d           = S_IDLE;
         step_d            = 2'd0;
         grp_d             = '0;
         ngrp_d            = ngrp_q;
         mode_d            = mode_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mapping_group_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mapping_group_ctrl
// Description : Self-checking bench for mapping_group_ctrl. The reference is
//               a queue of expected strobe tokens built from the run length
//               and mode, consumed as beats arrive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mapping_group_ctrl;

   localparam int GRP_W = 4;
   localparam int K_W1 = 0, K_W2 = 1, K_RD = 2, K_AC = 3, K_DR = 4, K_DN = 5;

   logic             clk_i = 1'b0;
   logic             rst_i, start_i, abort_i, mode_i, adc_valid_i;
   logic [GRP_W-1:0] num_groups_i;
   logic             adc_ready_o, buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o;
   logic             mode_o, accum_buf_write_o, accum_buf_read_o, busy_o, done_o;
   logic [1:0]       shift_count_o;
   logic [GRP_W-1:0] group_idx_o;

   typedef struct {int kind; int step; int grp;} tok_t;
   tok_t q[$];
   int   m_mode;
   int   cyc;
   int   done_cyc;
   int   t0;
   int   npass  = 0;
   int   ntotal = 0;

   always #5 clk_i = ~clk_i;

   mapping_group_ctrl #(.GRP_W(GRP_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .mode_i(mode_i), .num_groups_i(num_groups_i), .adc_valid_i(adc_valid_i),
      .adc_ready_o(adc_ready_o), .buf_write_en_1_o(buf_write_en_1_o),
      .buf_write_en_2_o(buf_write_en_2_o), .buf_read_en_o(buf_read_en_o),
      .mode_o(mode_o), .shift_count_o(shift_count_o),
      .accum_buf_write_o(accum_buf_write_o), .accum_buf_read_o(accum_buf_read_o),
      .group_idx_o(group_idx_o), .busy_o(busy_o), .done_o(done_o)
   );

   // One comparison: counts it, and reports it when it does not hold.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Expected token sequence of a whole run.
   function automatic void build(input int mode, input int n);
      q.delete();
      for (int g = 0; g < n; g++) begin
         for (int s = 0; s < 4; s++) begin
            q.push_back('{K_W1, s, g});
            if (mode != 0) q.push_back('{K_W2, s, g});
            q.push_back('{K_RD, s, g});
            q.push_back('{K_AC, s, g});
         end
         q.push_back('{K_DR, 3, g});
      end
      q.push_back('{K_DN, -1, -1});
   endfunction

   // One clock: compare outputs with the model at the falling edge, then advance.
   task automatic cycle();
      logic [5:0] exp_s, obs_s;
      logic       exp_ready;
      tok_t       t;
      @(negedge clk_i);
      exp_s     = 6'b0;
      exp_ready = 1'b0;
      t         = '{-1, -1, -1};
      if (q.size() != 0) t = q[0];
      if (!abort_i && q.size() != 0) begin
         case (t.kind)
            K_W1: begin exp_ready = 1'b1; exp_s = adc_valid_i ? 6'b100000 : 6'b0; end
            K_W2: begin exp_ready = 1'b1; exp_s = adc_valid_i ? 6'b010000 : 6'b0; end
            K_RD: exp_s = 6'b001000;
            K_AC: exp_s = 6'b000100;
            K_DR: exp_s = 6'b000010;
            default: exp_s = 6'b000001;
         endcase
      end
      obs_s = {buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o,
               accum_buf_write_o, accum_buf_read_o, done_o};
      chk("strobes", obs_s, exp_s);
      chk("onehot0", $onehot0(obs_s[5:1]), 1);
      chk("busy", busy_o, q.size() != 0);
      if (!abort_i) chk("ready", adc_ready_o, exp_ready);
      if (!abort_i && q.size() != 0 && t.kind != K_DN) begin
         chk("shift_count", shift_count_o, t.step);
         chk("group_idx", group_idx_o, t.grp);
         chk("mode", mode_o, m_mode);
      end
      if (done_o) done_cyc = cyc;
      if (abort_i) q.delete();
      else if (q.size() != 0) begin
         if ((t.kind == K_W1 || t.kind == K_W2) && !adc_valid_i) begin end
         else void'(q.pop_front());
      end else if (start_i) begin
         build(mode_i, num_groups_i);
         if (num_groups_i != 0) m_mode = mode_i;
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic do_start(input int mode, input int n);
      start_i = 1'b1; mode_i = mode[0]; num_groups_i = n[GRP_W-1:0];
      t0 = cyc; done_cyc = -1;
      cycle();
      start_i = 1'b0;
   endtask

   task automatic run_to_idle(input int budget);
      int k;
      k = 0;
      while (q.size() != 0 && k < budget) begin cycle(); k++; end
      chk("run_timeout", q.size(), 0);
   endtask

   task automatic all_zero(input string tag);
      chk(tag, {adc_ready_o, buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o,
                accum_buf_write_o, accum_buf_read_o, busy_o, done_o, mode_o,
                shift_count_o, group_idx_o}, 0);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0;
      adc_valid_i = 1'b0; num_groups_i = '0; cyc = 0; m_mode = 0; done_cyc = -1;
      repeat (2) @(posedge clk_i);
      #1;
      all_zero("reset_outputs");
      rst_i = 1'b0;
      cycle();

      // Single group, mode 0, valid always high.
      adc_valid_i = 1'b1;
      do_start(0, 1);
      run_to_idle(40);
      chk("m0_done_cycle", done_cyc - t0, 14);

      // Two groups, mode 1.
      do_start(1, 2);
      run_to_idle(80);
      chk("m1_done_cycle", done_cyc - t0, 35);

      // Valid gap of 3 cycles in WAIT1 of step 2, mode 0.
      do_start(0, 1);
      for (int k = 0; k < 40 && !(q[0].kind == K_W1 && q[0].step == 2); k++) cycle();
      adc_valid_i = 1'b0;
      repeat (3) cycle();
      adc_valid_i = 1'b1;
      run_to_idle(40);
      chk("gap_done_cycle", done_cyc - t0, 17);

      // Zero-length run.
      do_start(1, 0);
      run_to_idle(5);
      chk("zero_done_cycle", done_cyc - t0, 1);

      // Abort in WAIT2 of step 1 with a beat present, then a fresh run.
      do_start(1, 1);
      for (int k = 0; k < 40 && !(q[0].kind == K_W2 && q[0].step == 1); k++) cycle();
      abort_i = 1'b1;
      cycle();
      abort_i = 1'b0;
      cycle();
      chk("abort_no_done", done_cyc, 32'hFFFF_FFFF);
      do_start(1, 1);
      run_to_idle(40);
      chk("post_abort_done", done_cyc - t0, 18);

      // Asynchronous reset in ACCUM of step 1.
      do_start(1, 2);
      for (int k = 0; k < 40 && !(q[0].kind == K_AC && q[0].step == 1); k++) cycle();
      chk("pre_reset_shift", shift_count_o, 1);
      #1 rst_i = 1'b1;
      #1;
      all_zero("async_reset");
      q.delete(); m_mode = 0;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      cycle();

      // Random valid, random start/mode/count noise while busy.
      for (int r = 0; r < 3; r++) begin
         int k;
         do_start(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
         k = 0;
         while (q.size() != 0 && k < 400) begin
            adc_valid_i  = $urandom_range(0, 1);
            start_i      = $urandom_range(0, 1);
            mode_i       = $urandom_range(0, 1);
            num_groups_i = GRP_W'($urandom_range(0, 15));
            cycle();
            k++;
         end
         start_i = 1'b0;
         chk("rand_timeout", q.size(), 0);
      end
      cycle();

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
`default_nettype wire
